// File: rtl/jam_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : jam_pkg                                                    |
// | Description : Shared constants, cost/row types and feeder FSM states     |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
package jam_pkg;

  localparam int COST_W = 7;
  localparam int N      = 8;
  localparam int NN     = N * N;

  typedef logic [COST_W-1:0] cost_t;
  typedef cost_t [N-1:0]     row_t;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } feed_state_e;

endpackage
`default_nettype wire

// File: rtl/jam_cost_buf.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : jam_cost_buf                                               |
// | Description : N x N cost register file, row write port, element read     |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module jam_cost_buf #(
  parameter int  COST_W = 7,
  parameter int  N      = 8,
  localparam int IW     = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_wr_en,
  input  logic [IW-1:0]       i_wr_row,
  input  logic [N*COST_W-1:0] i_wr_data,
  input  logic [IW-1:0]       i_rd_row,
  input  logic [IW-1:0]       i_rd_col,
  output logic [COST_W-1:0]   o_rd_data
);
  import jam_pkg::*;

  logic [N*COST_W-1:0] r_mem [N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) r_mem[i] <= '0;
    end else if (i_wr_en) begin
      r_mem[i_wr_row] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_row][i_rd_col*COST_W +: COST_W];

endmodule
`default_nettype wire

// File: rtl/jam_cost_feeder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : jam_cost_feeder                                            |
// | Description : Buffers an 8x8 cost matrix row by row, streams it to the   |
// |               JAM engine as one 64-beat burst, waits for its 8 results.  |
// | Options     : JAM_FEED_TRANSPOSE_EN selects column-major streaming       |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module jam_cost_feeder #(
  parameter int COST_W = 7,
  parameter int N      = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                row_valid,
  input  logic [N*COST_W-1:0] row_data,
  output logic                row_ready,
  output logic                in_valid,
  output logic [COST_W-1:0]   in_cost,
  input  logic                jam_out_valid,
  output logic                busy,
  output logic [7:0]          done_cnt
);
  import jam_pkg::*;

  localparam int IW = $clog2(N);
  localparam int KW = 2 * IW;

  feed_state_e         r_state;
  feed_state_e         w_state_nxt;
  logic [IW-1:0]       r_row;
  logic [KW-1:0]       r_k;
  logic [3:0]          r_wcnt;
  logic [7:0]          r_done_cnt;
  logic                r_in_valid;
  logic [COST_W-1:0]   r_in_cost;
  logic                w_accept;
  logic                w_last_beat;
  logic                w_wait_done;
  logic [IW-1:0]       w_rd_row;
  logic [IW-1:0]       w_rd_col;
  logic [COST_W-1:0]   w_rd_data;

  assign w_accept    = (r_state == LOAD) && row_valid;
  assign w_last_beat = (r_state == SEND) && (&r_k);
  assign w_wait_done = (r_state == WAIT) && jam_out_valid && (r_wcnt == 4'd7);

`ifdef JAM_FEED_TRANSPOSE_EN
  assign w_rd_row = r_k[IW-1:0];
  assign w_rd_col = r_k[KW-1:IW];
`else
  assign w_rd_row = r_k[KW-1:IW];
  assign w_rd_col = r_k[IW-1:0];
`endif

  jam_cost_buf #(
    .COST_W (COST_W),
    .N      (N)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_accept),
    .i_wr_row  (r_row),
    .i_wr_data (row_data),
    .i_rd_row  (w_rd_row),
    .i_rd_col  (w_rd_col),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= LOAD;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    row_ready   = 1'b0;
    busy        = 1'b1;
    case (r_state)
      LOAD: begin
        row_ready = 1'b1;
        busy      = 1'b0;
        if (w_accept && (&r_row)) w_state_nxt = SEND;
      end
      SEND: if (w_last_beat) w_state_nxt = WAIT;
      WAIT: if (w_wait_done) w_state_nxt = LOAD;
      default: w_state_nxt = LOAD;
    endcase
  end

  // Row and beat indices wrap naturally to 0 on the last row / last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row      <= '0;
      r_k        <= '0;
      r_wcnt     <= '0;
      r_done_cnt <= '0;
      r_in_valid <= 1'b0;
      r_in_cost  <= '0;
    end else begin
      r_in_valid <= (r_state == SEND);
      r_in_cost  <= (r_state == SEND) ? w_rd_data : '0;
      if (w_accept) r_row <= r_row + 1'b1;
      if (r_state == SEND) r_k <= r_k + 1'b1;
      else                 r_k <= '0;
      if ((r_state == WAIT) && jam_out_valid) begin
        if (r_wcnt == 4'd7) begin
          r_wcnt     <= '0;
          r_done_cnt <= r_done_cnt + 1'b1;
        end else begin
          r_wcnt <= r_wcnt + 1'b1;
        end
      end
    end
  end

  assign in_valid = r_in_valid;
  assign in_cost  = r_in_cost;
  assign done_cnt = r_done_cnt;

endmodule
`default_nettype wire

// File: tb/tb_jam_cost_feeder.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_jam_cost_feeder                                         |
// | Description : Self-checking bench for jam_cost_feeder (matrix model)     |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module tb_jam_cost_feeder;

  localparam int COST_W = 7;
  localparam int N      = 8;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                row_valid = 1'b0;
  logic [N*COST_W-1:0] row_data = '0;
  logic                jam_out_valid = 1'b0;
  logic                row_ready;
  logic                in_valid;
  logic [COST_W-1:0]   in_cost;
  logic                busy;
  logic [7:0]          done_cnt;

  int checks = 0;
  int errors = 0;
  int exp_done = 0;
  logic [COST_W-1:0] mat [N][N];

  typedef struct {
    int   kind;
    int   row_gap;
    bit   rand_gap;
    bit   spurious;
    bit   bp;
    int   latency;
    int   res_gap;
    logic [7:0] exp_done;
  } vec_t;

  vec_t tbl [6];

  always #5 clk = ~clk;

  jam_cost_feeder #(.COST_W(COST_W), .N(N)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .row_valid     (row_valid),
    .row_data      (row_data),
    .row_ready     (row_ready),
    .in_valid      (in_valid),
    .in_cost       (in_cost),
    .jam_out_valid (jam_out_valid),
    .busy          (busy),
    .done_cnt      (done_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic void fill_matrix(input int kind);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        case (kind)
          0:       mat[r][c] = COST_W'(7*r + c);
          2:       mat[r][c] = '1;
          3:       mat[r][c] = COST_W'((r*N + c) ^ 'h55);
          default: mat[r][c] = COST_W'($urandom);
        endcase
  endfunction

  function automatic logic [N*COST_W-1:0] pack_row(input int r);
    logic [N*COST_W-1:0] v;
    for (int c = 0; c < N; c++) v[c*COST_W +: COST_W] = mat[r][c];
    return v;
  endfunction

  // Order in which the engine must see the matrix.
  function automatic logic [COST_W-1:0] exp_beat(input int k);
`ifdef JAM_FEED_TRANSPOSE_EN
    return mat[k % N][k / N];
`else
    return mat[k / N][k % N];
`endif
  endfunction

  task automatic load_rows(input int nrows, input int gap, input bit rgap, input bit spur);
    for (int r = 0; r < nrows; r++) begin
      int g;
      g = rgap ? int'($urandom_range(0, 3)) : gap;
      for (int i = 0; i < g; i++) begin
        row_valid = 1'b0;
        row_data  = {$urandom, $urandom};
        jam_out_valid = spur;
        tick;
      end
      row_valid = 1'b1;
      row_data  = pack_row(r);
      jam_out_valid = spur && r[0];
      check("row_ready_load", row_ready, 1);
      tick;
    end
    row_valid = 1'b0;
    jam_out_valid = 1'b0;
  endtask

  task automatic stream(input int nbeats, input bit bp, input bit spur);
    check("in_valid_e0", in_valid, 0);
    check("busy_send", busy, 1);
    check("row_ready_send", row_ready, 0);
    for (int k = 0; k < nbeats; k++) begin
      row_valid = bp;
      row_data  = {$urandom, $urandom};
      jam_out_valid = spur && (k % 5 == 0);
      tick;
      check("in_valid_beat", in_valid, 1);
      check("in_cost_beat", in_cost, exp_beat(k));
      check("row_ready_bp", row_ready, 0);
    end
    jam_out_valid = 1'b0;
  endtask

  task automatic finish_wait(input int latency, input int gap, input bit bp);
    tick;
    check("in_valid_end", in_valid, 0);
    check("in_cost_idle", in_cost, 0);
    for (int i = 0; i < latency; i++) begin
      row_valid = bp;
      tick;
      check("row_ready_wait", row_ready, 0);
      check("busy_wait", busy, 1);
    end
    for (int p = 0; p < 8; p++) begin
      for (int g = 0; g < gap; g++) begin
        jam_out_valid = 1'b0;
        tick;
        check("row_ready_gap", row_ready, 0);
      end
      jam_out_valid = 1'b1;
      tick;
      if (p < 7) begin
        check("row_ready_pulse", row_ready, 0);
        check("done_hold", done_cnt, 32'(exp_done));
      end else begin
        exp_done = (exp_done + 1) % 256;
        check("row_ready_back", row_ready, 1);
        check("done_inc", done_cnt, 32'(exp_done));
        check("busy_load", busy, 0);
      end
    end
    jam_out_valid = 1'b0;
    row_valid = 1'b0;
  endtask

  task automatic apply_reset_mid;
    #2;
    rst_n = 1'b0;
    #1;
    exp_done = 0;
    check("rst_in_valid", in_valid, 0);
    check("rst_in_cost", in_cost, 0);
    check("rst_done", done_cnt, 0);
    check("rst_row_ready", row_ready, 1);
    tick;
    rst_n = 1'b1;
    tick;
  endtask

  initial begin
    tbl[0] = '{0, 0, 1'b0, 1'b0, 1'b0, 3, 0, 8'd1};
    tbl[1] = '{1, 2, 1'b0, 1'b0, 1'b0, 0, 1, 8'd2};
    tbl[2] = '{2, 0, 1'b0, 1'b0, 1'b1, 5, 2, 8'd3};
    tbl[3] = '{3, 1, 1'b0, 1'b1, 1'b0, 2, 0, 8'd4};
    tbl[4] = '{1, 0, 1'b1, 1'b1, 1'b1, 10, 1, 8'd5};
    tbl[5] = '{1, 0, 1'b1, 1'b0, 1'b0, 0, 3, 8'd6};

    tick;
    check("reset_row_ready", row_ready, 1);
    check("reset_in_valid", in_valid, 0);
    check("reset_in_cost", in_cost, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done_cnt, 0);
    rst_n = 1'b1;
    tick;

    for (int i = 0; i < 6; i++) begin
      fill_matrix(tbl[i].kind);
      load_rows(N, tbl[i].row_gap, tbl[i].rand_gap, tbl[i].spurious);
      stream(N*N, tbl[i].bp, tbl[i].spurious);
      finish_wait(tbl[i].latency, tbl[i].res_gap, tbl[i].bp);
      check("tbl_done", done_cnt, 32'(tbl[i].exp_done));
    end

    // Partial load discarded by reset; next load must restart at row 0.
    fill_matrix(1);
    load_rows(3, 0, 1'b0, 1'b0);
    apply_reset_mid;
    fill_matrix(3);
    load_rows(N, 0, 1'b0, 1'b0);
    stream(N*N, 1'b0, 1'b0);
    finish_wait(1, 0, 1'b0);

    // Reset asserted mid-burst at beat 30.
    fill_matrix(0);
    load_rows(N, 0, 1'b0, 1'b0);
    stream(31, 1'b0, 1'b0);
    apply_reset_mid;
    fill_matrix(1);
    load_rows(N, 1, 1'b0, 1'b0);
    stream(N*N, 1'b0, 1'b0);
    finish_wait(2, 0, 1'b0);

    for (int i = 0; i < 255; i++) begin
      fill_matrix(1);
      load_rows(N, 0, 1'b1, 1'($urandom_range(0, 1)));
      stream(N*N, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      finish_wait(int'($urandom_range(0, 4)), int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    check("done_wrap", done_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
